// File: rtl/ram_dump_uart_if.sv
// ram_dump_uart_if
//   Request/grant read port between the dump engine and the shared output RAM.
//   The dump engine (master) raises ram_req and waits for ram_gnt before it
//   strobes ram_en with ram_addr; the RAM answers on ram_rdata after its
//   read latency.
//   Signals:
//     ram_req    master -> slave  request for the RAM port
//     ram_gnt    slave  -> master arbiter grant (dump address selected while high)
//     ram_en     master -> slave  one-cycle read strobe
//     ram_addr   master -> slave  read address
//     ram_rdata  slave  -> master read data
interface ram_dump_uart_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              ram_req;
  logic              ram_gnt;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_req,
    output ram_en,
    output ram_addr,
    input  ram_gnt,
    input  ram_rdata
  );

  modport slave (
    input  ram_req,
    input  ram_en,
    input  ram_addr,
    output ram_gnt,
    output ram_rdata
  );
endinterface

// File: rtl/ram_dump_uart.sv
// ram_dump_uart
//   On a rising edge of the CPU's start level, waits START_DELAY cycles, then
//   fetches WORDS consecutive words from the shared RAM (one request/grant
//   handshake per word) and streams each word over an 8N1 UART, either as raw
//   bytes (MSB byte first) or as uppercase ASCII hex followed by CR LF.
//   Ports:
//     clk      system clock
//     reset    synchronous, active-high
//     start    CPU dump-enable level; a rising edge arms a dump
//     ram      RAM request/grant read port (master side)
//     uart_tx  serial output, idle high
//     busy     high from the accepted start edge until the dump completes
//     done     sticky completion flag, cleared by the next accepted start
module ram_dump_uart #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 6,
  parameter int BASE_ADDR    = 0,
  parameter int WORDS        = 64,
  parameter int START_DELAY  = 15,
  parameter int CLKS_PER_BIT = 868,
  parameter int RAM_LAT      = 1,
  parameter int HEX_MODE     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  ram_dump_uart_if.master     ram,
  output logic                uart_tx,
  output logic                busy,
  output logic                done
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int NNIB     = DATA_W / 4;
  localparam int NCHARS   = (HEX_MODE != 0) ? (NNIB + 2) : NBYTES;
  localparam int CHAR_W   = $clog2(NCHARS + 1);
  localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS + 1) : 1;
  localparam int DLY_LAST = (START_DELAY > 0) ? (START_DELAY - 1) : 0;
  localparam int DLY_W    = (DLY_LAST > 0) ? $clog2(DLY_LAST + 1) : 1;
  localparam int CLK_W    = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_REQ,
    S_READ,
    S_WAIT,
    S_LOAD,
    S_TX,
    S_FIN
  } state_t;

  state_t            state;
  logic              start_q;
  logic [DLY_W-1:0]  dly_cnt;
  logic [1:0]        lat_cnt;
  logic [WIDX_W-1:0] word_idx;
  logic [CHAR_W-1:0] char_idx;
  logic [DATA_W-1:0] word_q;
  logic [8:0]        tx_shift;
  logic [3:0]        bit_cnt;
  logic [CLK_W-1:0]  clk_cnt;
  logic              start_edge;
  logic [7:0]        cur_byte;

  assign start_edge = start & ~start_q;

  // Character selector: char_idx always points at the next character of the
  // captured word still to be sent, so the same value feeds both the first
  // frame (from LOAD) and the back-to-back frames launched at the end of a
  // stop bit.
  always_comb begin
    int         idx;
    logic [3:0] nib;
    idx      = int'(char_idx);
    nib      = 4'h0;
    cur_byte = 8'h00;
    if (HEX_MODE == 0) begin
      if (idx < NBYTES) begin
        cur_byte = word_q[(NBYTES - 1 - idx) * 8 +: 8];
      end
    end else begin
      if (idx < NNIB) begin
        nib      = word_q[(NNIB - 1 - idx) * 4 +: 4];
        cur_byte = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
      end else if (idx == NNIB) begin
        cur_byte = 8'h0D;
      end else begin
        cur_byte = 8'h0A;
      end
    end
  end

  // Dump sequencer. Every output is a register so the RAM port and the
  // serial line never see combinational glitches. The stop-bit end launches
  // the next frame directly (start bit on the following cycle) so bytes of a
  // word go out with no idle gap between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      dly_cnt      <= '0;
      lat_cnt      <= 2'd0;
      word_idx     <= '0;
      char_idx     <= '0;
      word_q       <= '0;
      tx_shift     <= '1;
      bit_cnt      <= 4'd0;
      clk_cnt      <= '0;
      ram.ram_req  <= 1'b0;
      ram.ram_en   <= 1'b0;
      ram.ram_addr <= ADDR_W'(BASE_ADDR);
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q    <= start;
      ram.ram_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            done         <= 1'b0;
            busy         <= 1'b1;
            word_idx     <= '0;
            ram.ram_addr <= ADDR_W'(BASE_ADDR);
            dly_cnt      <= '0;
            state        <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_cnt == DLY_W'(DLY_LAST)) begin
            ram.ram_req <= 1'b1;
            state       <= S_REQ;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (ram.ram_gnt) begin
            ram.ram_en <= 1'b1;
            state      <= S_READ;
          end
        end
        S_READ: begin
          // Losing the grant here means the strobe may not have reached the
          // RAM with our address, so the whole access is repeated.
          if (!ram.ram_gnt) begin
            state <= S_REQ;
          end else begin
            lat_cnt <= 2'd0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ram.ram_gnt) begin
            state <= S_REQ;
          end else if (lat_cnt == 2'(RAM_LAT - 1)) begin
            word_q      <= ram.ram_rdata;
            ram.ram_req <= 1'b0;
            char_idx    <= '0;
            state       <= S_LOAD;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          tx_shift <= {1'b1, cur_byte};
          uart_tx  <= 1'b0;
          char_idx <= char_idx + 1'b1;
          bit_cnt  <= 4'd0;
          clk_cnt  <= '0;
          state    <= S_TX;
        end
        S_TX: begin
          if (clk_cnt == CLK_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              if (char_idx == CHAR_W'(NCHARS)) begin
                word_idx <= word_idx + 1'b1;
                if (word_idx == WIDX_W'(WORDS - 1)) begin
                  state <= S_FIN;
                end else begin
                  ram.ram_addr <= ram.ram_addr + 1'b1;
                  ram.ram_req  <= 1'b1;
                  state        <= S_REQ;
                end
              end else begin
                tx_shift <= {1'b1, cur_byte};
                uart_tx  <= 1'b0;
                char_idx <= char_idx + 1'b1;
                bit_cnt  <= 4'd0;
              end
            end else begin
              // Shift in ones from the top so the stop bit follows the data.
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
